// File: rtl/qnigma_crypt_pkg.sv
// Shared X25519 key types and the RFC 7748 byte-string decoders used by the
// key loader and the ladder.
package qnigma_crypt_pkg;

  localparam int KEY_BYTES = 32;

  typedef logic [255:0] key_t;
  typedef logic [KEY_BYTES-1:0][7:0] kbuf_t;
  typedef enum logic {KEY_SCALAR = 1'b0, KEY_U = 1'b1} key_typ_t;

  // k[KEY_BYTES-1] is the first wire byte, i.e. the least significant byte.
  function automatic key_t dec_litte_endian(input kbuf_t k);
    key_t r;
    for (int i = 0; i < KEY_BYTES; i++) begin
      r[8*i +: 8] = k[KEY_BYTES-1-i];
    end
    return r;
  endfunction

  function automatic key_t dec_scalar_25519(input kbuf_t k);
    kbuf_t c;
    c = k;
    c[KEY_BYTES-1] = c[KEY_BYTES-1] & 8'hf8;
    c[0] = (c[0] & 8'h7f) | 8'h40;
    return dec_litte_endian(c);
  endfunction

  function automatic key_t dec_u_25519(input kbuf_t k);
    kbuf_t c;
    c = k;
    c[0] = c[0] & 8'h7f;
    return dec_litte_endian(c);
  endfunction

endpackage

// File: rtl/qnigma_key_loader.sv
// Collects a 32-byte little-endian key field from a byte stream, checks its
// framing and hands the decoded 256-bit integer to the X25519 ladder.
module qnigma_key_loader
  import qnigma_crypt_pkg::key_t,
         qnigma_crypt_pkg::kbuf_t,
         qnigma_crypt_pkg::key_typ_t,
         qnigma_crypt_pkg::KEY_SCALAR,
         qnigma_crypt_pkg::dec_scalar_25519,
         qnigma_crypt_pkg::dec_u_25519;
#(
  parameter int KEY_BYTES    = 32,
  parameter bit DRAIN_ON_ERR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_dat,
  input  logic         in_val,
  input  logic         in_lst,
  input  logic         in_typ,
  output logic         in_rdy,
  output logic [255:0] key,
  output logic         key_typ,
  output logic         key_val,
  input  logic         key_rdy,
  output logic         err
);

  if (KEY_BYTES != qnigma_crypt_pkg::KEY_BYTES) begin : g_bad_key_bytes
    $error("qnigma_key_loader: KEY_BYTES must match key_t (32)");
  end

  localparam logic [4:0] CNT_LAST = 5'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_COLLECT, ST_DECODE, ST_HOLD, ST_DRAIN
  } state_t;

  state_t    state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  kbuf_t     shift_q, shift_d;
  key_typ_t  typ_q, typ_d;
  key_t      key_q, key_d;
  key_typ_t  key_typ_q, key_typ_d;
  logic      key_val_q, key_val_d;
  logic      in_rdy_q, in_rdy_d;
  logic      err_q, err_d;
  logic      accept;

  assign accept = in_val && in_rdy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    typ_d     = typ_q;
    key_d     = key_q;
    key_typ_d = key_typ_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = {shift_q[KEY_BYTES-2:0], in_dat};
          typ_d   = key_typ_t'(in_typ);
          if (in_lst) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d   = 5'd1;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          shift_d = {shift_q[KEY_BYTES-2:0], in_dat};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (in_lst) begin
              state_d = ST_DECODE;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN_ON_ERR ? ST_DRAIN : ST_IDLE;
            end
          end else if (in_lst) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DECODE: begin
        key_d     = (typ_q == KEY_SCALAR) ? dec_scalar_25519(shift_q) : dec_u_25519(shift_q);
        key_typ_d = typ_q;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (key_val_q && key_rdy) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (accept && in_lst) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered, so they follow the state being entered.
    key_val_d = (state_d == ST_HOLD);
    in_rdy_d  = (state_d == ST_IDLE) || (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      typ_q     <= KEY_SCALAR;
      key_q     <= '0;
      key_typ_q <= KEY_SCALAR;
      key_val_q <= 1'b0;
      in_rdy_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      typ_q     <= typ_d;
      key_q     <= key_d;
      key_typ_q <= key_typ_d;
      key_val_q <= key_val_d;
      in_rdy_q  <= in_rdy_d;
      err_q     <= err_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign key     = key_q;
  assign key_typ = key_typ_q;
  assign key_val = key_val_q;
  assign err     = err_q;

endmodule

// File: tb/tb_qnigma_key_loader.sv
// Self-checking bench for qnigma_key_loader: fixed vectors, framing errors,
// backpressure, mid-frame reset and randomized frames against a byte-level model.
module tb_qnigma_key_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_dat;
  logic         in_val;
  logic         in_lst;
  logic         in_typ;
  logic         in_rdy;
  logic [255:0] key;
  logic         key_typ;
  logic         key_val;
  logic         key_rdy;
  logic         err;

  int checks     = 0;
  int errors     = 0;
  int err_pulses = 0;
  int kv_rises   = 0;
  logic kv_prev  = 1'b0;
  logic [7:0] frm [0:63];

  always #5 clk = ~clk;

  qnigma_key_loader #(.KEY_BYTES(32), .DRAIN_ON_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_val(in_val), .in_lst(in_lst),
    .in_typ(in_typ), .in_rdy(in_rdy), .key(key), .key_typ(key_typ),
    .key_val(key_val), .key_rdy(key_rdy), .err(err)
  );

  always @(negedge clk) begin
    if (err === 1'b1) err_pulses++;
    if (key_val === 1'b1 && kv_prev !== 1'b1) kv_rises++;
    kv_prev = key_val;
  end

  // Wire byte i carries bits 8i+7..8i; scalars get RFC 7748 clamping, u values lose bit 255.
  function automatic logic [255:0] model_key(input logic typ);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v = v + (256'(frm[i]) << (8 * i));
    if (typ) begin
      v = v % (256'd1 << 255);
    end else begin
      v = v - (v % 256'd8);
      v = v % (256'd1 << 255);
      v = v | (256'd1 << 254);
    end
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic t, input logic l);
    int guard;
    guard  = 0;
    in_dat = d; in_typ = t; in_lst = l; in_val = 1'b1;
    while (in_rdy !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_rdy !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL in_rdy_timeout: in_rdy=%b required 1", in_rdy);
    end
    @(posedge clk); #1;
    in_val = 1'b0; in_lst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_val = 1'b0; in_lst = 1'b0; in_typ = 1'b0; in_dat = '0; key_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_rdy: got %b want 0", in_rdy); end
    if (key_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_val: got %b want 0", key_val); end
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    if (key !== 256'd0) begin errors++; $display("[TB] FAIL reset_key: got %h want 0", key); end
    if (key_typ !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_typ: got %b want 0", key_typ); end
    rst = 1'b0;
  endtask

  task automatic test_scalar_vector();
    logic [7:0] vec [0:31] = '{
      8'ha5, 8'h46, 8'he3, 8'h6b, 8'hf0, 8'h52, 8'h7c, 8'h9d, 8'h3b, 8'h16, 8'h15, 8'h4b,
      8'h82, 8'h46, 8'h5e, 8'hdd, 8'h62, 8'h14, 8'h4c, 8'h0a, 8'hc1, 8'hfc, 8'h5a, 8'h18,
      8'h50, 8'h6a, 8'h22, 8'h44, 8'hba, 8'h44, 8'h9a, 8'hc4};
    logic [255:0] want;
    int e0;
    want = 256'h449a44ba44226a50185afcc10a4c1462dd5e46824b15163b9d7c52f06be346a0;
    e0 = err_pulses;
    for (int i = 0; i < 32; i++) frm[i] = vec[i];
    for (int i = 0; i < 32; i++) send_byte(frm[i], 1'b0, i == 31);
    checks++;
    if (key_val !== 1'b0) begin errors++; $display("[TB] FAIL scalar_latency_early: key_val=%b want 0", key_val); end
    @(posedge clk); #1;
    checks += 5;
    if (key_val !== 1'b1) begin errors++; $display("[TB] FAIL scalar_latency: key_val=%b want 1", key_val); end
    if (key !== want) begin errors++; $display("[TB] FAIL scalar_key: got %h want %h", key, want); end
    if (key !== model_key(1'b0)) begin errors++; $display("[TB] FAIL scalar_model: got %h want %h", key, model_key(1'b0)); end
    if (key_typ !== 1'b0) begin errors++; $display("[TB] FAIL scalar_typ: got %b want 0", key_typ); end
    if (err_pulses != e0) begin errors++; $display("[TB] FAIL scalar_err: pulses %0d want %0d", err_pulses, e0); end
    key_rdy = 1'b1;
    @(posedge clk); #1;
    key_rdy = 1'b0;
    checks += 2;
    if (key_val !== 1'b0) begin errors++; $display("[TB] FAIL scalar_release: key_val=%b want 0", key_val); end
    if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL scalar_in_rdy: in_rdy=%b want 1", in_rdy); end
  endtask

  task automatic test_u_ones();
    logic [255:0] want;
    want = ~256'd0 >> 1;
    for (int i = 0; i < 32; i++) frm[i] = 8'hff;
    for (int i = 0; i < 32; i++) send_byte(frm[i], 1'b1, i == 31);
    @(posedge clk); #1;
    checks += 4;
    if (key_val !== 1'b1) begin errors++; $display("[TB] FAIL u_key_val: got %b want 1", key_val); end
    if (key !== want) begin errors++; $display("[TB] FAIL u_key: got %h want %h", key, want); end
    if (key !== model_key(1'b1)) begin errors++; $display("[TB] FAIL u_model: got %h want %h", key, model_key(1'b1)); end
    if (key_typ !== 1'b1) begin errors++; $display("[TB] FAIL u_typ: got %b want 1", key_typ); end
    key_rdy = 1'b1;
    @(posedge clk); #1;
    key_rdy = 1'b0;
  endtask

  task automatic test_random_frames(input int n);
    logic t;
    logic [255:0] want;
    int e0;
    for (int f = 0; f < n; f++) begin
      t  = 1'($urandom_range(0, 1));
      e0 = err_pulses;
      for (int i = 0; i < 32; i++) frm[i] = 8'($urandom);
      want = model_key(t);
      for (int i = 0; i < 32; i++) send_byte(frm[i], t, i == 31);
      checks++;
      if (key_val !== 1'b0) begin errors++; $display("[TB] FAIL rand_latency_early: key_val=%b want 0", key_val); end
      @(posedge clk); #1;
      checks += 4;
      if (key_val !== 1'b1) begin errors++; $display("[TB] FAIL rand_key_val: got %b want 1", key_val); end
      if (key !== want) begin errors++; $display("[TB] FAIL rand_key: got %h want %h", key, want); end
      if (key_typ !== t) begin errors++; $display("[TB] FAIL rand_typ: got %b want %b", key_typ, t); end
      if (err_pulses != e0) begin errors++; $display("[TB] FAIL rand_err: pulses %0d want %0d", err_pulses, e0); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      key_rdy = 1'b1;
      @(posedge clk); #1;
      key_rdy = 1'b0;
      checks++;
      if (key_val !== 1'b0) begin errors++; $display("[TB] FAIL rand_release: key_val=%b want 0", key_val); end
    end
  endtask

  task automatic test_short_frame();
    int e0, k0;
    e0 = err_pulses; k0 = kv_rises;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0, i == 9);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL short_err_pulse: err=%b want 1", err); end
    send_byte(8'($urandom), 1'b1, 1'b1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL one_byte_err_pulse: err=%b want 1", err); end
    repeat (4) @(posedge clk);
    #1;
    checks += 3;
    if (err_pulses != e0 + 2) begin errors++; $display("[TB] FAIL short_err_count: got %0d want %0d", err_pulses, e0 + 2); end
    if (kv_rises != k0) begin errors++; $display("[TB] FAIL short_key_val: rises %0d want %0d", kv_rises, k0); end
    if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL short_idle: in_rdy=%b want 1", in_rdy); end
  endtask

  task automatic test_long_frame();
    int e0, k0;
    e0 = err_pulses; k0 = kv_rises;
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom), 1'b0, i == 39);
      if (i == 31) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL long_err_at_32: err=%b want 1", err); end
      end else if (i > 31) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL long_drain_err: byte %0d err=%b want 0", i + 1, err); end
      end
    end
    repeat (4) @(posedge clk);
    #1;
    checks += 3;
    if (err_pulses != e0 + 1) begin errors++; $display("[TB] FAIL long_err_count: got %0d want %0d", err_pulses, e0 + 1); end
    if (kv_rises != k0) begin errors++; $display("[TB] FAIL long_key_val: rises %0d want %0d", kv_rises, k0); end
    if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL long_idle: in_rdy=%b want 1", in_rdy); end
  endtask

  task automatic test_backpressure();
    logic [255:0] want;
    for (int i = 0; i < 32; i++) frm[i] = 8'($urandom);
    want = model_key(1'b0);
    for (int i = 0; i < 32; i++) send_byte(frm[i], 1'b0, i == 31);
    @(posedge clk); #1;
    in_val = 1'b1; in_lst = 1'b0; in_dat = 8'($urandom);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_rdy: cycle %0d got %b want 0", c, in_rdy); end
      if (key_val !== 1'b1) begin errors++; $display("[TB] FAIL bp_key_val: cycle %0d got %b want 1", c, key_val); end
      if (key !== want) begin errors++; $display("[TB] FAIL bp_key: cycle %0d got %h want %h", c, key, want); end
    end
    key_rdy = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0; key_rdy = 1'b0;
    checks += 3;
    if (key_val !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: key_val=%b want 0", key_val); end
    if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready: in_rdy=%b want 1", in_rdy); end
    if (key !== want) begin errors++; $display("[TB] FAIL bp_key_kept: got %h want %h", key, want); end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 17; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_in_rdy: got %b want 0", in_rdy); end
    if (key_val !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_key_val: got %b want 0", key_val); end
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_err: got %b want 0", err); end
    if (key !== 256'd0) begin errors++; $display("[TB] FAIL mid_rst_key: got %h want 0", key); end
    if (key_typ !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_key_typ: got %b want 0", key_typ); end
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] starting qnigma_key_loader bench");
    test_reset();
    test_scalar_vector();
    test_u_ones();
    test_random_frames(4);
    test_short_frame();
    test_random_frames(2);
    test_long_frame();
    test_random_frames(2);
    test_backpressure();
    test_reset_mid_frame();
    test_random_frames(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qnigma_key_loader.md
Name: qnigma_key_loader

Overview:
Byte-stream front end for the X25519 engine. Collects a 32-byte key field in wire order (RFC 7748 little-endian encoding) from an upstream valid/ready byte stream, checks the frame length, and decodes it. Scalars are clamped and reversed. u-coordinates have their top bit masked and are reversed. The result is presented as a 256-bit integer (key_t, byte 31 = most significant) on a valid/ready output to the ladder.

Parameters:
KEY_BYTES, 32, field length in bytes; fixed to match key_t, and any other value is a elaboration error.
DRAIN_ON_ERR, 1, 1 = after an over-length error, consume input bytes up to and including in_lst; 0 = return to IDLE at once.

Ports:
clk  in  1  system clock
rst  in  1  reset
in_dat  in  8  key byte, first byte = least significant byte of the encoding
in_val  in  1  in_dat valid
in_lst  in  1  last byte of the field
in_typ  in  1  0 = scalar, 1 = u-coordinate; sampled with the first accepted byte
in_rdy  out  1  loader accepts a byte
key  out  256 (key_t)  decoded integer, key[31] = MSB byte
key_typ  out  1  in_typ latched for this key
key_val  out  1  key valid
key_rdy  in  1  consumer accepts key
err  out  1  one-cycle pulse on a framing error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, cnt=0, buffer=0, key=0, key_typ=0, key_val=0, err=0, in_rdy=0.
- Acceptance: a byte is accepted on a cycle where in_val && in_rdy.
- States: IDLE, COLLECT, DECODE, HOLD, DRAIN.
- IDLE:
  - in_rdy=1.
  - On an accepted byte: shift it into the buffer (buf <= {buf[30:0], in_dat}), latch in_typ, set cnt=1, go to COLLECT.
  - If that byte also has in_lst=1: pulse err, go back to IDLE (1-byte frame).
- COLLECT:
  - in_rdy=1. Each accepted byte shifts in and increments cnt.
  - Accepted byte with in_lst=1 and cnt<31 (short frame): pulse err, clear cnt, go to IDLE.
  - Accepted byte with cnt==31 and in_lst=1: go to DECODE.
  - Accepted byte with cnt==31 and in_lst=0 (long frame): pulse err; go to DRAIN if DRAIN_ON_ERR, else IDLE.
- DECODE (one cycle, in_rdy=0):
  - typ=0: key <= dec_scalar_25519(buf).
  - typ=1: key <= dec_u_25519(buf).
  - Go to HOLD.
  - key_val rises on the cycle after DECODE. Latency from the 32nd byte accepted to key_val=1 is 2 cycles.
- HOLD:
  - in_rdy=0; key_val=1; key and key_typ are held stable.
  - key_val && key_rdy: key_val goes to 0 next cycle, go to IDLE. key keeps its old value until the next DECODE.
- DRAIN:
  - in_rdy=1; bytes are discarded.
  - Accepted byte with in_lst=1: go to IDLE. No further err pulses.
- in_val low mid-frame: stall indefinitely with no timeout; cnt holds.
- err: exactly one cycle per malformed frame and never asserted together with key_val rising. A good frame following a bad one decodes normally.
- rst in any state, including mid-frame or HOLD: immediate return to reset values. The partial frame is lost, and upstream must resend from byte 0.
- No reduction mod p; non-canonical u values pass through unchanged, per RFC 7748.

Decomposition:
- Shared package qnigma_crypt_pkg already holds key_t, dec_litte_endian and dec_scalar_25519.
- Add to that package:
  - function dec_u_25519: k[0] &= 127, then dec_litte_endian.
  - enum typedef key_typ_t {KEY_SCALAR=0, KEY_U=1}.
  - localparam KEY_BYTES=32.
- No sub-module: a single FSM plus a shift buffer.

Test Plan:
- Scalar: send bytes a5 46 e3 6b f0 52 7c 9d 3b 16 15 4b 82 46 5e dd 62 14 4c 0a c1 fc 5a 18 50 6a 22 44 ba 44 9a c4, typ=0, in_lst on byte 32 -> key=0x449a44ba44226a50185afcc10a4c1462dd5e46824b15163b9d7c52f06be346a0, key_typ=0, key_val 2 cycles after the last byte.
- u-coordinate: 32 bytes of 0xff, typ=1 -> key=0x7fff...ff (bit 255 clear, no clamping of low bits).
- Short frame: in_lst on byte 10 -> one err pulse, no key_val; a following valid frame decodes correctly.
- Long frame: 40 bytes with in_lst on byte 40, DRAIN_ON_ERR=1 -> err pulse at byte 32, bytes 33-40 consumed, back in IDLE, no key_val.
- Backpressure: hold key_rdy=0 for 20 cycles with in_val=1 -> in_rdy=0, key stable; key_rdy=1 -> key_val drops next cycle and in_rdy=1.
- Reset mid-frame: rst after byte 17 -> all outputs at reset values next cycle; a fresh 32-byte frame yields the correct key.
